// File: rtl/regfile_bypass_if.sv
// Operand-read and pipeline-result bundle between decode/execute and regfile_bypass.
// master = pipeline side driving addresses and results, slave = register file.
interface regfile_bypass_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
) ();
  localparam int AW = $clog2(NREG);

  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic                ex_valid;
  logic                ex_is_load;
  logic [AW-1:0]       ex_rdt;
  logic [XLEN-1:0]     ex_result;
  logic [XLEN-1:0]     mem_load_data;
  logic                stall;

  modport master (
    output rd_en, rd_addr, ex_valid, ex_is_load, ex_rdt, ex_result, mem_load_data,
    input  rd_data, stall
  );

  modport slave (
    input  rd_en, rd_addr, ex_valid, ex_is_load, ex_rdt, ex_result, mem_load_data,
    output rd_data, stall
  );
endinterface

// File: rtl/regfile_bypass.sv
// Register file with one M-stage write-back, EX/M operand forwarding and load-use stall.
// Define REGFILE_FWD_EN for forwarding; without it every in-flight producer stalls decode.
module regfile_bypass #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int NRD   = 2,
  parameter int CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  regfile_bypass_if.slave          bus,
  input  logic [$clog2(NREG)-1:0]  dbg_addr_i,
  output logic [XLEN-1:0]          dbg_data_o,
  output logic [CNT_W-1:0]         stall_count_o
);
  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0]     regs_q [NREG];
  logic                m_valid_q;
  logic                m_is_load_q;
  logic [AW-1:0]       m_rdt_q;
  logic [XLEN-1:0]     m_result_q;
  logic [XLEN-1:0]     m_wdata;
  logic [CNT_W-1:0]    stall_count_q;
  logic [CNT_W-1:0]    stall_count_d;
  logic [AW-1:0]       port_addr [NRD];
  logic [NRD-1:0]      port_hazard;
  logic [NRD*XLEN-1:0] rd_data;
  logic                stall;

  assign m_wdata = m_is_load_q ? bus.mem_load_data : m_result_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_valid_q <= 1'b0;
    end else begin
      m_valid_q   <= bus.ex_valid;
      m_is_load_q <= bus.ex_is_load;
      m_rdt_q     <= bus.ex_rdt;
      m_result_q  <= bus.ex_result;
    end
  end

  // NOTE: the array is cleared by reset because software relies on all registers reading 0 afterwards.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
    end else if (m_valid_q && (m_rdt_q != '0)) begin
      regs_q[m_rdt_q] <= m_wdata;
    end
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      port_addr[i] = bus.rd_addr[i*AW +: AW];
    end
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    rd_data     = '0;
    port_hazard = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_data[i*XLEN +: XLEN] = regs_q[port_addr[i]];
`ifdef REGFILE_FWD_EN
      // EX is checked last so the younger producer overrides M.
      if (m_valid_q && (m_rdt_q == port_addr[i])) begin
        rd_data[i*XLEN +: XLEN] = m_wdata;
      end
      if (bus.ex_valid && !bus.ex_is_load && (bus.ex_rdt == port_addr[i])) begin
        rd_data[i*XLEN +: XLEN] = bus.ex_result;
      end
      port_hazard[i] = bus.rd_en[i] && bus.ex_valid && bus.ex_is_load &&
                       (bus.ex_rdt == port_addr[i]);
`else
      port_hazard[i] = bus.rd_en[i] &&
                       ((bus.ex_valid && (bus.ex_rdt == port_addr[i])) ||
                        (m_valid_q && (m_rdt_q == port_addr[i])));
`endif
      if (port_addr[i] == '0) begin
        rd_data[i*XLEN +: XLEN] = '0;
        port_hazard[i]          = 1'b0;
      end
    end
  end

  assign stall       = |port_hazard;
  assign bus.stall   = stall;
  assign bus.rd_data = rd_data;

  assign dbg_data_o = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count_o = stall_count_q;
endmodule
